alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 4-bit operation code produced by the ALU control decoder and the two register/immediate operands.
- Single-cycle ops (AND, OR, ADD, SUB, SLT, NOR) complete with a registered result one cycle after start.
- Adds an iterative unsigned shift-add multiplier (MULTU) so the datapath can gain multiply without a combinational array.
- A busy/done handshake lets the control path stall while a multiply is in flight.

---
 rtl/alu_exec_unit.sv | 205 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops with registered
// results, plus an iterative unsigned shift-add multiplier (MULTU).
// The multiplier uses a busy/done handshake so the control path can stall
// while a multiply is in flight.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             invalid_op,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Signed overflow of a sum: equal operand signs, result sign differs.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic r_msb);
        add_ovf = (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow of a difference: differing operand signs, result
    // sign differs from the minuend.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                     input logic r_msb);
        sub_ovf = (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;
    logic                 inv_q, inv_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [WIDTH-1:0]     sum_s;
    logic [WIDTH-1:0]     diff_s;
    logic                 slt_s;
    logic [WIDTH-1:0]     alu_res_s;
    logic                 alu_ovf_s;
    logic                 alu_inv_s;

    assign sum_s  = a + b;
    assign diff_s = a - b;
    assign slt_s  = ($signed(a) < $signed(b));

    // Single-cycle operation decode; anything unrecognised (including X)
    // yields a zero result flagged as invalid.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
        alu_inv_s = 1'b0;
        case (alu_ctrl)
            OP_AND: alu_res_s = a & b;
            OP_OR:  alu_res_s = a | b;
            OP_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff_s[WIDTH-1]);
            end
            OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_NOR: alu_res_s = ~(a | b);
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_inv_s = 1'b1;
            end
        endcase
    end

    // Next-state logic: launch ops from IDLE, iterate the shift-add
    // multiplier in MUL and publish its product once the counter expires.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (alu_ctrl == OP_MULTU) begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = {(2*WIDTH){1'b0}};
                        cnt_d    = CW'(WIDTH);
                        busy_d   = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        result_d = alu_res_s;
                        zero_d   = (alu_res_s == {WIDTH{1'b0}});
                        ovf_d    = alu_ovf_s;
                        inv_d    = alu_inv_s;
                        done_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                // start is deliberately ignored here: no capture, no queue.
                if (cnt_q != {CW{1'b0}}) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end else begin
                        acc_d = acc_q;
                    end
                    mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                    cnt_d    = cnt_q - CW'(1);
                end else begin
                    result_d = acc_q[WIDTH-1:0];
                    hi_d     = acc_q[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_q[WIDTH-1:0] == {WIDTH{1'b0}});
                    ovf_d    = 1'b0;
                    inv_d    = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any partial product.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result     = result_q;
    assign hi         = hi_q;
    assign zero       = zero_q;
    assign overflow   = ovf_q;
    assign invalid_op = inv_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized
// single-cycle ops and multiplies against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  result;
    logic [W-1:0]  hi;
    logic          zero;
    logic          overflow;
    logic          invalid_op;
    logic          busy;
    logic          done;

    int n_cmp;
    int n_err;

    // Reference-model view of the architected outputs.
    logic [W-1:0]  exp_res;
    logic [W-1:0]  exp_hi;
    logic          exp_zero;
    logic          exp_ovf;
    logic          exp_inv;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alu_ctrl   (alu_ctrl),
        .a          (a),
        .b          (b),
        .result     (result),
        .hi         (hi),
        .zero       (zero),
        .overflow   (overflow),
        .invalid_op (invalid_op),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Arithmetic model of a single-cycle op, written from the op rules.
    task automatic model_op(input logic [3:0] code, input logic [W-1:0] x,
                            input logic [W-1:0] y);
        longint sx;
        longint sy;
        longint s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        exp_ovf = 1'b0;
        exp_inv = 1'b0;
        case (code)
            4'b0000: exp_res = x & y;
            4'b0001: exp_res = x | y;
            4'b0010: begin
                s = sx + sy;
                exp_res = W'(s);
                exp_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s = sx - sy;
                exp_res = W'(s);
                exp_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: exp_res = (sx < sy) ? 32'd1 : 32'd0;
            4'b1100: exp_res = ~(x | y);
            default: begin
                exp_res = 32'd0;
                exp_inv = 1'b1;
            end
        endcase
        exp_zero = (exp_res == 32'd0);
    endtask

    task automatic check_all(input string tag, input logic exp_done);
        chk({tag, ".result"}, 64'(result), 64'(exp_res));
        chk({tag, ".zero"}, 64'(zero), 64'(exp_zero));
        chk({tag, ".overflow"}, 64'(overflow), 64'(exp_ovf));
        chk({tag, ".invalid"}, 64'(invalid_op), 64'(exp_inv));
        chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, ".done"}, 64'(done), 64'(exp_done));
    endtask

    // Issue one single-cycle op; start is left asserted for back-to-back use.
    task automatic op_cycle(input string tag, input logic [3:0] code,
                            input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        alu_ctrl = code;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        model_op(code, x, y);
        check_all(tag, 1'b1);
    endtask

    task automatic idle_cycle(input string tag);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        @(posedge clk);
        #1;
        check_all(tag, 1'b0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
    endtask

    // Launch a MULTU and wait (bounded) for done; optionally pulse an ADD
    // start mid-flight, which must be ignored.
    task automatic mul_op(input string tag, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit poke);
        logic [63:0] p;
        int got;
        int busy_bad;
        start = 1'b1;
        alu_ctrl = 4'b1000;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".busy_start"}, 64'(busy), 64'd1);
        chk({tag, ".done_start"}, 64'(done), 64'd0);
        got = 0;
        busy_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (poke && k == 5) begin
                start = 1'b1;
                alu_ctrl = 4'b0010;
                a = 32'd1;
                b = 32'd1;
            end else begin
                start = 1'b0;
                a = $urandom;
                b = $urandom;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                got = k;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 64'(got), 64'd33);
        chk({tag, ".busy_held"}, 64'(busy_bad), 64'd0);
        p = {32'd0, x} * {32'd0, y};
        exp_res  = p[31:0];
        exp_hi   = p[63:32];
        exp_zero = (p[31:0] == 32'd0);
        exp_ovf  = 1'b0;
        exp_inv  = 1'b0;
        check_all(tag, 1'b1);
        chk({tag, ".busy_end"}, 64'(busy), 64'd0);
    endtask

    logic [3:0] codes [0:9];

    initial begin
        n_cmp = 0;
        n_err = 0;
        codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010;
        codes[3] = 4'b0110; codes[4] = 4'b0111; codes[5] = 4'b1100;
        codes[6] = 4'b1111; codes[7] = 4'b0011; codes[8] = 4'b1010;
        codes[9] = 4'b0101;
        reset = 1'b1;
        start = 1'b1;
        alu_ctrl = 4'b0010;
        a = 32'd3;
        b = 32'd4;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        exp_res = 32'd0; exp_hi = 32'd0; exp_zero = 1'b0;
        exp_ovf = 1'b0;  exp_inv = 1'b0;
        check_all("reset", 1'b0);
        chk("reset.busy", 64'(busy), 64'd0);

        // ADD overflow into sign bit.
        op_cycle("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1);
        chk("add_ovf.val", 64'(result), 64'h8000_0000);
        idle_cycle("add_hold");

        // Back-to-back SUB then SLT.
        op_cycle("sub_eq", 4'b0110, 32'd5, 32'd5);
        op_cycle("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1);
        chk("slt_neg.val", 64'(result), 64'd1);
        idle_cycle("b2b_hold");

        // MULTU corner: max * max.
        mul_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("mul_max.hi", 64'(hi), 64'hFFFF_FFFE);
        idle_cycle("mul_hold");

        // Start ignored while busy.
        mul_op("mul_ign", 32'd3, 32'd7, 1'b1);
        chk("mul_ign.val", 64'(result), 64'd21);
        idle_cycle("ign_no_extra_done");

        // Reset in the middle of a multiply.
        start = 1'b1;
        alu_ctrl = 4'b1000;
        a = 32'd6;
        b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_res = 32'd0; exp_hi = 32'd0; exp_zero = 1'b0;
        exp_ovf = 1'b0;  exp_inv = 1'b0;
        check_all("mid_reset", 1'b0);
        chk("mid_reset.busy", 64'(busy), 64'd0);
        op_cycle("post_reset_add", 4'b0010, 32'd2, 32'd3);
        idle_cycle("post_reset_hold");
        idle_cycle("post_reset_quiet");

        // Invalid code followed by a valid AND.
        op_cycle("invalid", 4'b1111, 32'h1234, 32'h5678);
        op_cycle("and_after", 4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
        idle_cycle("and_hold");

        // SUB overflow corners.
        op_cycle("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1);
        op_cycle("sub_ovf2", 4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        op_cycle("nor_zero", 4'b1100, 32'hFFFF_FFFF, 32'd0);
        idle_cycle("corner_hold");

        // Randomized back-to-back single-cycle ops.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) x = {x[31], 31'd0} | 32'h7FFF_FFFF & {32{x[0]}};
            if ($urandom_range(0, 3) == 0) y = x;
            op_cycle("rand_op", codes[$urandom_range(0, 9)], x, y);
            if ($urandom_range(0, 4) == 0) idle_cycle("rand_hold");
        end
        idle_cycle("rand_end");

        // Randomized multiplies.
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = $urandom;
            y = (i == 0) ? 32'd0 : $urandom;
            mul_op("rand_mul", x, y, 1'b0);
            op_cycle("after_mul", 4'b0001, $urandom, $urandom);
        end
        idle_cycle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
